// File: rtl/text_writer_pkg.sv
// Shared constants, state encoding and control-character codes for the text writer.
package text_writer_pkg;
    localparam int unsigned COLS_DEFAULT = 64;
    localparam int unsigned ROWS_DEFAULT = 16;
    localparam int unsigned ROW_W        = 4;
    localparam int unsigned COL_W        = 6;
    localparam int unsigned ADDR_W       = ROW_W + COL_W;
    localparam int unsigned DATA_W       = 8;

    localparam logic [DATA_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [DATA_W-1:0] CHAR_LF = 8'h0A;
    localparam logic [DATA_W-1:0] CHAR_BS = 8'h08;
    localparam logic [DATA_W-1:0] CHAR_FF = 8'h0C;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/text_writer_if.sv
// Character/cursor input and display-RAM write bus of the text writer.
interface text_writer_if;
    import text_writer_pkg::*;

    logic              char_valid;
    logic [DATA_W-1:0] char_data;
    logic              char_ready;
    logic              clear_req;
    logic              set_cursor;
    logic [ROW_W-1:0]  cursor_row_in;
    logic [COL_W-1:0]  cursor_col_in;
    logic [ADDR_W-1:0] ram_Adr;
    logic [DATA_W-1:0] ram_Data;
    logic              write_Ram;
    logic              busy;
    logic [ROW_W-1:0]  cursor_row;
    logic [COL_W-1:0]  cursor_col;

    modport master (
        output char_valid, char_data, clear_req, set_cursor, cursor_row_in, cursor_col_in,
        input  char_ready, ram_Adr, ram_Data, write_Ram, busy, cursor_row, cursor_col
    );

    modport slave (
        input  char_valid, char_data, clear_req, set_cursor, cursor_row_in, cursor_col_in,
        output char_ready, ram_Adr, ram_Data, write_Ram, busy, cursor_row, cursor_col
    );
endinterface

// File: rtl/text_cursor.sv
// Row/column cursor with advance, newline, carriage return, backspace and load; wraps without scrolling.
module text_cursor
    import text_writer_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEFAULT,
    parameter int unsigned ROWS = ROWS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_home,
    input  logic             i_load,
    input  logic [ROW_W-1:0] i_row,
    input  logic [COL_W-1:0] i_col,
    input  logic             i_advance,
    input  logic             i_newline,
    input  logic             i_cr,
    input  logic             i_bs,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col
);
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_col_last;
    logic [ROW_W-1:0] w_row_inc;

    assign w_col_last = (r_col == COL_W'(COLS - 1));
    assign w_row_inc  = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);

    always_ff @(posedge clk) begin
        if (reset || i_home) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_load) begin
            r_row <= i_row;
            r_col <= i_col;
        end else if (i_advance) begin
            r_col <= w_col_last ? '0 : r_col + COL_W'(1);
            if (w_col_last)
                r_row <= w_row_inc;
        end else if (i_newline) begin
            r_row <= w_row_inc;
        end else if (i_cr) begin
            r_col <= '0;
        end else if (i_bs && (r_col != '0)) begin
            r_col <= r_col - COL_W'(1);
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;
endmodule

// File: rtl/text_writer.sv
// Writes characters into a COLS x ROWS display RAM at the cursor and clears the screen on request/reset.
// Optional macro TEXT_WRITER_CTRL_CHARS_EN: CR/LF/BS/FF act as controls instead of glyphs.
module text_writer
    import text_writer_pkg::*;
#(
    parameter int unsigned       COLS       = COLS_DEFAULT,
    parameter int unsigned       ROWS       = ROWS_DEFAULT,
    parameter logic [DATA_W-1:0] CLEAR_CHAR = 8'h20
) (
    input  logic          clk,
    input  logic          reset,
    text_writer_if.slave  bus
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_cnt;
    logic [ADDR_W-1:0] r_adr, w_adr;
    logic [DATA_W-1:0] r_data, w_data;
    logic              r_wr, w_wr;
    logic              w_load, w_advance, w_newline, w_cr, w_bs;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_adr     <= '0;
            r_data    <= '0;
            r_wr      <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_clr_cnt <= w_clr_cnt;
            r_adr     <= w_adr;
            r_data    <= w_data;
            r_wr      <= w_wr;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_clr_cnt = r_clr_cnt;
        w_adr     = r_adr;
        w_data    = r_data;
        w_wr      = 1'b0;
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_newline = 1'b0;
        w_cr      = 1'b0;
        w_bs      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.clear_req) begin
                    w_next    = CLEAR;
                    w_clr_cnt = '0;
                end else if (bus.set_cursor) begin
                    w_load = 1'b1;
                end else if (bus.char_valid) begin
`ifdef TEXT_WRITER_CTRL_CHARS_EN
                    case (bus.char_data)
                        CHAR_CR: w_cr      = 1'b1;
                        CHAR_LF: w_newline = 1'b1;
                        CHAR_BS: w_bs      = 1'b1;
                        CHAR_FF: begin
                            w_next    = CLEAR;
                            w_clr_cnt = '0;
                        end
                        default: begin
                            w_wr      = 1'b1;
                            w_adr     = {w_row, w_col};
                            w_data    = bus.char_data;
                            w_advance = 1'b1;
                        end
                    endcase
`else
                    w_wr      = 1'b1;
                    w_adr     = {w_row, w_col};
                    w_data    = bus.char_data;
                    w_advance = 1'b1;
`endif
                end
            end
            CLEAR: begin
                w_wr      = 1'b1;
                w_adr     = r_clr_cnt;
                w_data    = CLEAR_CHAR;
                w_clr_cnt = r_clr_cnt + ADDR_W'(1);
                if (r_clr_cnt == ADDR_W'(COLS * ROWS - 1))
                    w_next = IDLE;
            end
        endcase
    end

    // Cursor is held at home for every clear cycle, so it leaves CLEAR at (0,0).
    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .i_home    (r_state == CLEAR),
        .i_load    (w_load),
        .i_row     (bus.cursor_row_in),
        .i_col     (bus.cursor_col_in),
        .i_advance (w_advance),
        .i_newline (w_newline),
        .i_cr      (w_cr),
        .i_bs      (w_bs),
        .o_row     (w_row),
        .o_col     (w_col)
    );

    assign bus.busy       = (r_state == CLEAR);
    assign bus.char_ready = (r_state == IDLE) && !bus.clear_req && !bus.set_cursor;
    assign bus.ram_Adr    = r_adr;
    assign bus.ram_Data   = r_data;
    assign bus.write_Ram  = r_wr;
    assign bus.cursor_row = w_row;
    assign bus.cursor_col = w_col;
endmodule

// File: tb/tb_text_writer.sv
// Directed, table-driven bench for text_writer: boot clear, character writes, cursor wrap,
// control characters (when TEXT_WRITER_CTRL_CHARS_EN is defined) and clear/reset interplay.
module tb_text_writer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    text_writer_if bus ();

    text_writer #(
        .COLS       (64),
        .ROWS       (16),
        .CLEAR_CHAR (8'h20)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       valid;
        logic [7:0] data;
        logic       setc;
        logic [3:0] row;
        logic [5:0] col;
        logic       exp_ready;
        logic       exp_wr;
        logic [9:0] exp_adr;
        logic [7:0] exp_data;
        logic [3:0] exp_row;
        logic [5:0] exp_col;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.char_valid    = 1'b0;
        bus.char_data     = 8'h00;
        bus.clear_req     = 1'b0;
        bus.set_cursor    = 1'b0;
        bus.cursor_row_in = 4'd0;
        bus.cursor_col_in = 6'd0;
    endtask

    task automatic add(input string n, input logic v, input logic [7:0] d, input logic s,
                       input logic [3:0] r, input logic [5:0] c, input logic er, input logic ew,
                       input logic [9:0] ea, input logic [7:0] ed, input logic [3:0] eR,
                       input logic [5:0] eC);
        vec_t t;
        t.name = n; t.valid = v; t.data = d; t.setc = s; t.row = r; t.col = c;
        t.exp_ready = er; t.exp_wr = ew; t.exp_adr = ea; t.exp_data = ed;
        t.exp_row = eR; t.exp_col = eC;
        vecs.push_back(t);
    endtask

    // Expects the first clear write at the next edge; with noise, clear/set/char inputs are
    // hammered for a few cycles and must be ignored.
    task automatic run_clear(input string name, input int stop_at, input bit noise);
        int bad = 0;
        for (int i = 0; i < stop_at; i++) begin
            if (noise && i >= 100 && i < 110) begin
                bus.char_valid = 1'b1; bus.char_data = 8'h55;
                bus.set_cursor = 1'b1; bus.clear_req = 1'b1;
                bus.cursor_row_in = 4'd9; bus.cursor_col_in = 6'd9;
            end else begin
                idle_inputs();
            end
            step();
            if (bus.write_Ram !== 1'b1) bad++;
            if (bus.ram_Adr !== 10'(i)) bad++;
            if (bus.ram_Data !== 8'h20) bad++;
            if (i < 1023 && (bus.busy !== 1'b1 || bus.char_ready !== 1'b0)) bad++;
        end
        idle_inputs();
        chk({name, "_writes"}, bad, 0);
        if (stop_at == 1024) begin
            chk({name, "_ready_at_1024"}, bus.char_ready, 1'b1);
            step();
            chk({name, "_wr_after"}, bus.write_Ram, 1'b0);
            chk({name, "_busy_after"}, bus.busy, 1'b0);
            chk({name, "_hold_adr"}, bus.ram_Adr, 10'h3FF);
            chk({name, "_cursor"}, {bus.cursor_row, bus.cursor_col}, 10'h000);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        chk("rst_busy", bus.busy, 1'b1);
        chk("rst_ready", bus.char_ready, 1'b0);
        chk("rst_wr", bus.write_Ram, 1'b0);
        chk("rst_adr", bus.ram_Adr, 10'h000);
        chk("rst_data", bus.ram_Data, 8'h00);
        chk("rst_cursor", {bus.cursor_row, bus.cursor_col}, 10'h000);
        reset = 1'b0;
        run_clear("boot", 1024, 1'b0);

        //   name        vld data  setc row col  rdy wr adr     data   row col
        add("char_A",    1, 8'h41, 0, 0,  0,   1, 1, 10'h000, 8'h41, 0,  1);
        add("idle_hold", 0, 8'h99, 0, 0,  0,   1, 0, 10'h000, 8'h41, 0,  1);
        add("set_0_63",  0, 8'h00, 1, 0,  63,  0, 0, 10'h000, 8'h41, 0,  63);
        add("col_wrap",  1, 8'h43, 0, 0,  0,   1, 1, 10'h03F, 8'h43, 1,  0);
        add("set_15_63", 0, 8'h00, 1, 15, 63,  0, 0, 10'h03F, 8'h43, 15, 63);
        add("end_wrap",  1, 8'h42, 0, 0,  0,   1, 1, 10'h3FF, 8'h42, 0,  0);
        add("set_7_5",   0, 8'h00, 1, 7,  5,   0, 0, 10'h3FF, 8'h42, 7,  5);
        add("char_7E",   1, 8'h7E, 0, 0,  0,   1, 1, 10'h1C5, 8'h7E, 7,  6);
        add("char_00",   1, 8'h00, 0, 0,  0,   1, 1, 10'h1C6, 8'h00, 7,  7);
        add("set_wins",  1, 8'h55, 1, 3,  3,   0, 0, 10'h1C6, 8'h00, 3,  3);
        add("set_2_10",  0, 8'h00, 1, 2,  10,  0, 0, 10'h1C6, 8'h00, 2,  10);
`ifdef TEXT_WRITER_CTRL_CHARS_EN
        add("ctl_cr",    1, 8'h0D, 0, 0,  0,   1, 0, 10'h1C6, 8'h00, 2,  0);
        add("ctl_lf",    1, 8'h0A, 0, 0,  0,   1, 0, 10'h1C6, 8'h00, 3,  0);
        add("ctl_bs_0",  1, 8'h08, 0, 0,  0,   1, 0, 10'h1C6, 8'h00, 3,  0);
        add("set_3_5",   0, 8'h00, 1, 3,  5,   0, 0, 10'h1C6, 8'h00, 3,  5);
        add("ctl_bs",    1, 8'h08, 0, 0,  0,   1, 0, 10'h1C6, 8'h00, 3,  4);
`else
        add("glyph_0D",  1, 8'h0D, 0, 0,  0,   1, 1, 10'h08A, 8'h0D, 2,  11);
        add("glyph_08",  1, 8'h08, 0, 0,  0,   1, 1, 10'h08B, 8'h08, 2,  12);
`endif

        foreach (vecs[k]) begin
            bus.char_valid    = vecs[k].valid;
            bus.char_data     = vecs[k].data;
            bus.set_cursor    = vecs[k].setc;
            bus.cursor_row_in = vecs[k].row;
            bus.cursor_col_in = vecs[k].col;
            #1;
            chk({vecs[k].name, "_ready"}, bus.char_ready, vecs[k].exp_ready);
            step();
            idle_inputs();
            chk({vecs[k].name, "_wr"}, bus.write_Ram, vecs[k].exp_wr);
            chk({vecs[k].name, "_adr"}, bus.ram_Adr, vecs[k].exp_adr);
            chk({vecs[k].name, "_data"}, bus.ram_Data, vecs[k].exp_data);
            chk({vecs[k].name, "_cursor"}, {bus.cursor_row, bus.cursor_col},
                {vecs[k].exp_row, vecs[k].exp_col});
            if (vecs[k].exp_wr) begin
                step();
                chk({vecs[k].name, "_one_pulse"}, bus.write_Ram, 1'b0);
            end
        end

`ifdef TEXT_WRITER_CTRL_CHARS_EN
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h0C;
        step();
        idle_inputs();
        chk("ff_busy", bus.busy, 1'b1);
        chk("ff_no_write", bus.write_Ram, 1'b0);
        run_clear("ff_clear", 1024, 1'b0);
`endif

        // clear_req beats a simultaneous character; reset mid-clear restarts from address 0
        bus.clear_req  = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h77;
        #1;
        chk("clr_vs_char_ready", bus.char_ready, 1'b0);
        step();
        idle_inputs();
        chk("clr_start_busy", bus.busy, 1'b1);
        chk("clr_start_no_write", bus.write_Ram, 1'b0);
        run_clear("clr_partial", 500, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", bus.busy, 1'b1);
        chk("abort_wr", bus.write_Ram, 1'b0);
        chk("abort_adr", bus.ram_Adr, 10'h000);
        run_clear("clr_restart", 1024, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/text_writer.md
TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 The block SHALL have parameter COLS, default 64, meaning characters per row (power of two).
REQ-002 The block SHALL have parameter ROWS, default 16, meaning text rows; COLS*ROWS SHALL equal 1024.
REQ-003 The block SHALL have parameter CLEAR_CHAR, default 8'h20, meaning the glyph code written by a clear.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, which is also the display RAM write clock.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port char_valid, input, 1 bit: a character is offered.
REQ-007 The block SHALL have port char_data, input, 8 bits: the character code.
REQ-008 The block SHALL have port char_ready, output, 1 bit: the character is accepted when char_valid and char_ready are both high.
REQ-009 The block SHALL have port clear_req, input, 1 bit: a single-cycle request to clear the screen.
REQ-010 The block SHALL have port set_cursor, input, 1 bit: load the cursor from cursor_row_in and cursor_col_in.
REQ-011 The block SHALL have ports cursor_row_in, input, 4 bits, and cursor_col_in, input, 6 bits: the new cursor position.
REQ-012 The block SHALL have port ram_Adr, output, 10 bits: display RAM write address, laid out as {row[3:0], col[5:0]}.
REQ-013 The block SHALL have port ram_Data, output, 8 bits: display RAM write data.
REQ-014 The block SHALL have port write_Ram, output, 1 bit: display RAM write enable.
REQ-015 The block SHALL have port busy, output, 1 bit: a clear is in progress.
REQ-016 The block SHALL have ports cursor_row, output, 4 bits, and cursor_col, output, 6 bits: the current cursor position.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and CLEAR.
REQ-018 busy SHALL equal (state==CLEAR), and char_ready SHALL equal (state==IDLE && !clear_req && !set_cursor).
REQ-019 In IDLE, priority SHALL be clear_req, then set_cursor, then character acceptance; at most one of these acts per cycle.
REQ-020 A printable accept SHALL register ram_Adr={cursor_row,cursor_col}, ram_Data=char_data, write_Ram=1 at the next edge, giving latency 1 cycle.
REQ-021 write_Ram SHALL be high for exactly one cycle per written character.
REQ-022 After a printable write, the cursor SHALL advance: col+1; col 63 SHALL wrap to col 0 with row+1; row 15 SHALL wrap to row 0 with no scroll.
REQ-023 On clear_req in IDLE, the FSM SHALL enter CLEAR with clr_cnt=0.
REQ-024 On each CLEAR cycle, the block SHALL register ram_Adr=clr_cnt, ram_Data=CLEAR_CHAR, write_Ram=1, then increment clr_cnt.
REQ-025 After the write of address 1023, the FSM SHALL return to IDLE with the cursor at (0,0).
REQ-026 A clear SHALL take exactly 1024 consecutive write cycles.
REQ-027 clear_req, set_cursor and char_valid SHALL be ignored during CLEAR, and char_ready SHALL be low.
REQ-028 set_cursor SHALL load the cursor at the next edge and SHALL perform no RAM write.
REQ-029 When neither writing nor clearing, write_Ram SHALL be 0, and ram_Adr and ram_Data SHALL hold their last values.
REQ-030 All outputs except char_ready and busy SHALL be registered.

Reset
REQ-031 While reset is high, the block SHALL set state=CLEAR, clr_cnt=0, cursor=(0,0), ram_Adr=0, ram_Data=0 and write_Ram=0.
REQ-032 While reset is high, busy SHALL read 1 and char_ready SHALL read 0.
REQ-033 After reset releases, a full clear SHALL run: write_Ram is high on cycles 1..1024, and char_ready rises in cycle 1024.
REQ-034 Reset asserted mid-clear or mid-write SHALL abort the operation and restart the clear from address 0.

Configuration
REQ-035 With macro TEXT_WRITER_CTRL_CHARS_EN defined, the following SHALL be interpreted as controls and SHALL NOT be written to RAM:
- 8'h0D (CR): col=0.
- 8'h0A (LF): row+1 with wrap, col unchanged.
- 8'h08 (BS): col-1, saturating at 0.
- 8'h0C (FF): enter CLEAR.
REQ-036 Without TEXT_WRITER_CTRL_CHARS_EN, every accepted byte, including 8'h00-8'h1F, SHALL be written as a glyph and SHALL advance the cursor.

Structure
REQ-037 Package text_writer_pkg SHALL hold the state enum, the COLS/ROWS/address-width constants, and the CR/LF/BS/FF codes.
REQ-038 Sub-module text_cursor SHALL hold the row/col counter with advance, newline, carriage-return, backspace and load operations and wrap logic.

Verification
REQ-039 Reset for 3 cycles, then release -> write_Ram high for exactly 1024 cycles, addresses 0..1023 in order, ram_Data=8'h20, then char_ready=1 and cursor=(0,0).
REQ-040 After the clear, send "A" (8'h41) -> one cycle later ram_Adr=10'h000, ram_Data=8'h41, write_Ram=1, and cursor=(0,1).
REQ-041 set_cursor to (15,63), then send 8'h42 -> write at ram_Adr=10'h3FF, and cursor wraps to (0,0).
REQ-042 With TEXT_WRITER_CTRL_CHARS_EN at cursor (2,10): send 8'h0D then 8'h0A -> no write_Ram pulses, cursor=(3,0); 8'h08 at col 0 -> col stays 0.
REQ-043 Raise clear_req and char_valid in the same IDLE cycle -> char not accepted and clear starts; pulse reset at clear cycle 500 -> clear restarts at address 0 and completes 1024 writes.
